// File: rtl/spi_slave_wide.sv
// spi_slave_wide: parametrised SPI slave front end, one bit per clk
// cycle while SS_n is low, with frame-error reporting.
//
// Ports:
//   clk, rst         system clock, synchronous active-high reset
//   SS_n, MOSI       slave select (active low) and serial data in
//   MISO             serial data out, MSB first, 0 when idle
//   rx_valid         one-cycle pulse, rx_data holds a complete frame
//   rx_data          {command[1:0], payload[DATA_W-1:0]}
//   tx_valid/tx_data read data handed in while waiting in TX_WAIT
//   frame_err        one-cycle pulse on an aborted frame
//   busy             high whenever the FSM is not IDLE
//   parity_err       (SPI_WIDE_PARITY_EN only) rx parity mismatch pulse
//
// Optional macro SPI_WIDE_PARITY_EN adds an even-parity bit to every
// rx frame and to the tx data stream, and the parity_err output.
module spi_slave_wide #(
    parameter int DATA_W      = 8,
    parameter int TX_WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SS_n,
    input  logic              MOSI,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              MISO,
    output logic              rx_valid,
    output logic [DATA_W+1:0] rx_data,
    output logic              frame_err,
`ifdef SPI_WIDE_PARITY_EN
    output logic              parity_err,
`endif
    output logic              busy
);

    localparam int FRAME_W = DATA_W + 2;
`ifdef SPI_WIDE_PARITY_EN
    localparam int RX_BITS = FRAME_W + 1;
    localparam int TX_BITS = DATA_W + 1;
`else
    localparam int RX_BITS = FRAME_W;
    localparam int TX_BITS = DATA_W;
`endif
    localparam int CNT_W  = $clog2(RX_BITS + 1);
    localparam int WCNT_W = $clog2(TX_WAIT_MAX + 2);

    localparam logic [CNT_W-1:0]  RX_LAST = CNT_W'(RX_BITS - 1);
    localparam logic [CNT_W-1:0]  RX_DONE = CNT_W'(RX_BITS);
    localparam logic [CNT_W-1:0]  TX_DONE = CNT_W'(TX_BITS);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [WCNT_W-1:0] W_LAST  = WCNT_W'(TX_WAIT_MAX);
    // Wait counter parked here once the tx wait has timed out.
    localparam logic [WCNT_W-1:0] W_TOUT  = WCNT_W'(TX_WAIT_MAX + 1);
    localparam logic [WCNT_W-1:0] W_ONE   = WCNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA,
        TX_WAIT,
        TX_SHIFT
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [WCNT_W-1:0]   wcnt_q;
    logic [RX_BITS-2:0]  rx_sh_q;
    logic [TX_BITS-2:0]  tx_sh_q;
    logic                rd_addr_flag_q;
    logic                miso_q;
    logic                rx_valid_q;
    logic [FRAME_W-1:0]  rx_data_q;
    logic                frame_err_q;
`ifdef SPI_WIDE_PARITY_EN
    logic                parity_err_q;
`endif

    logic [RX_BITS-1:0]  rx_full_d;
    logic [FRAME_W-1:0]  frame_d;
    logic                par_ok_d;
    logic [TX_BITS-1:0]  tx_load_d;

    // Frame as it stands once the current MOSI bit is shifted in.
    assign rx_full_d = {rx_sh_q, MOSI};
    assign frame_d   = rx_full_d[RX_BITS-1 -: FRAME_W];

`ifdef SPI_WIDE_PARITY_EN
    // Even parity: frame bits plus parity bit hold an even count of ones.
    assign par_ok_d  = ~^rx_full_d;
    assign tx_load_d = {tx_data, ^tx_data};
`else
    assign par_ok_d  = 1'b1;
    assign tx_load_d = tx_data;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            wcnt_q         <= '0;
            rx_sh_q        <= '0;
            tx_sh_q        <= '0;
            rd_addr_flag_q <= 1'b0;
            miso_q         <= 1'b0;
            rx_valid_q     <= 1'b0;
            rx_data_q      <= '0;
            frame_err_q    <= 1'b0;
`ifdef SPI_WIDE_PARITY_EN
            parity_err_q   <= 1'b0;
`endif
        end else begin
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef SPI_WIDE_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            unique case (state_q)
                IDLE: begin
                    miso_q <= 1'b0;
                    cnt_q  <= '0;
                    wcnt_q <= '0;
                    if (!SS_n) begin
                        state_q <= CHK_CMD;
                    end
                end

                CHK_CMD: begin
                    cnt_q <= '0;
                    if (SS_n) begin
                        state_q     <= IDLE;
                        frame_err_q <= 1'b1;
                    end else if (!MOSI) begin
                        state_q <= WRITE;
                    end else if (rd_addr_flag_q) begin
                        state_q <= READ_DATA;
                    end else begin
                        state_q <= READ_ADD;
                    end
                end

                WRITE, READ_ADD, READ_DATA: begin
                    if (cnt_q == RX_DONE) begin
                        // Frame finished: ignore MOSI until deselect.
                        if (SS_n) begin
                            state_q <= IDLE;
                        end
                    end else if (SS_n) begin
                        state_q     <= IDLE;
                        frame_err_q <= 1'b1;
                    end else begin
                        rx_sh_q <= rx_full_d[RX_BITS-2:0];
                        cnt_q   <= cnt_q + CNT_ONE;
                        if (cnt_q == RX_LAST) begin
`ifdef SPI_WIDE_PARITY_EN
                            parity_err_q <= ~par_ok_d;
`endif
                            if (par_ok_d) begin
                                rx_valid_q <= 1'b1;
                                rx_data_q  <= frame_d;
                                if (state_q == READ_ADD) begin
                                    rd_addr_flag_q <= 1'b1;
                                end
                                if (state_q == READ_DATA) begin
                                    state_q <= TX_WAIT;
                                    wcnt_q  <= '0;
                                end
                            end
                        end
                    end
                end

                TX_WAIT: begin
                    miso_q <= 1'b0;
                    if (SS_n) begin
                        state_q <= IDLE;
                        // A timed-out frame has already reported its error.
                        if (wcnt_q != W_TOUT) begin
                            frame_err_q <= 1'b1;
                        end
                    end else if (wcnt_q == W_TOUT) begin
                        wcnt_q <= W_TOUT;
                    end else if (tx_valid) begin
                        state_q <= TX_SHIFT;
                        miso_q  <= tx_load_d[TX_BITS-1];
                        tx_sh_q <= tx_load_d[TX_BITS-2:0];
                        cnt_q   <= CNT_ONE;
                    end else if (wcnt_q == W_LAST) begin
                        frame_err_q <= 1'b1;
                        wcnt_q      <= W_TOUT;
                    end else begin
                        wcnt_q <= wcnt_q + W_ONE;
                    end
                end

                TX_SHIFT: begin
                    if (cnt_q == TX_DONE) begin
                        // Last bit has been on MISO for a full cycle.
                        miso_q         <= 1'b0;
                        rd_addr_flag_q <= 1'b0;
                        if (SS_n) begin
                            state_q <= IDLE;
                        end
                    end else if (SS_n) begin
                        state_q     <= IDLE;
                        miso_q      <= 1'b0;
                        frame_err_q <= 1'b1;
                    end else begin
                        miso_q  <= tx_sh_q[TX_BITS-2];
                        tx_sh_q <= tx_sh_q << 1;
                        cnt_q   <= cnt_q + CNT_ONE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    miso_q  <= 1'b0;
                end
            endcase
        end
    end

    assign MISO      = miso_q;
    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_data_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);
`ifdef SPI_WIDE_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_spi_slave_wide.sv
// Scoreboard bench for spi_slave_wide: stimulus pushes expected
// rx frames and error pulses, a negedge monitor pops and compares.
module tb_spi_slave_wide;

    localparam int DW  = 8;
    localparam int TWM = 15;
`ifdef SPI_WIDE_PARITY_EN
    localparam int RXB = 11;
    localparam int TXB = 9;
`else
    localparam int RXB = 10;
    localparam int TXB = 8;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          SS_n = 1'b0;
    logic          MOSI = 1'b0;
    logic          tx_valid = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic          MISO;
    logic          rx_valid;
    logic [DW+1:0] rx_data;
    logic          frame_err;
    logic          busy;
`ifdef SPI_WIDE_PARITY_EN
    logic          parity_err;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic [9:0] d;
        int         c;
    } rx_exp_t;

    rx_exp_t exp_rx[$];
    int      exp_err[$];
    int      exp_par[$];
    rx_exp_t mon_e;
    int      mon_c;

    spi_slave_wide #(
        .DATA_W(DW),
        .TX_WAIT_MAX(TWM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .SS_n(SS_n),
        .MOSI(MOSI),
        .tx_valid(tx_valid),
        .tx_data(tx_data),
        .MISO(MISO),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .frame_err(frame_err),
`ifdef SPI_WIDE_PARITY_EN
        .parity_err(parity_err),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every output pulse must match the head of its queue.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            if (exp_rx.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rx_valid_unexpected: got rx_data 0x%0h at cycle %0d expected no pulse",
                         rx_data, cyc);
            end else begin
                mon_e = exp_rx.pop_front();
                chk("rx_data", rx_data, mon_e.d);
                chk("rx_valid_cycle", cyc, mon_e.c);
            end
        end
        if (frame_err === 1'b1) begin
            if (exp_err.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL frame_err_unexpected: got pulse at cycle %0d expected none", cyc);
            end else begin
                mon_c = exp_err.pop_front();
                chk("frame_err_cycle", cyc, mon_c);
            end
        end
`ifdef SPI_WIDE_PARITY_EN
        if (parity_err === 1'b1) begin
            if (exp_par.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL parity_err_unexpected: got pulse at cycle %0d expected none", cyc);
            end else begin
                mon_c = exp_par.pop_front();
                chk("parity_err_cycle", cyc, mon_c);
            end
        end
`endif
    end

    task automatic sel_start(input logic sel, output int entry);
        @(negedge clk);
        SS_n  = 1'b0;
        entry = cyc + 1;
        @(negedge clk);
        MOSI = sel;
    endtask

    task automatic shift(input logic [9:0] b, input int n);
        for (int i = 9; i > 9 - n; i--) begin
            @(negedge clk);
            MOSI = b[i];
        end
`ifdef SPI_WIDE_PARITY_EN
        if (n == 10) begin
            @(negedge clk);
            MOSI = ^b;
        end
`endif
    endtask

    task automatic rx_frame(input logic sel, input logic [9:0] b);
        int e;
        sel_start(sel, e);
        exp_rx.push_back('{b, e + RXB + 1});
        shift(b, 10);
    endtask

    task automatic ss_up;
        @(negedge clk);
        SS_n = 1'b1;
    endtask

    logic [TXB-1:0] tx_exp;
    int             ent;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef SPI_WIDE_PARITY_EN
        tx_exp = 9'b0_1011_0100;
`else
        tx_exp = 8'b0101_1010;
`endif
        // Reset with SS_n low and MOSI toggling.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            MOSI = ~MOSI;
            chk("rst_miso", MISO, 0);
            chk("rst_rx_valid", rx_valid, 0);
            chk("rst_rx_data", rx_data, 0);
            chk("rst_frame_err", frame_err, 0);
            chk("rst_busy", busy, 0);
        end
        rst  = 1'b0;
        SS_n = 1'b1;

        // Write address, with extra MOSI bits after completion.
        rx_frame(1'b0, 10'b00_1010_0101);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            MOSI = 1'b1;
        end
        chk("busy_after_frame", busy, 1);
        ss_up();

        // Write data back-to-back, SS_n high for one cycle.
        rx_frame(1'b0, 10'b01_1100_0011);
        ss_up();

        // Abort after 2 command and 4 payload bits.
        sel_start(1'b0, ent);
        shift(10'b00_1111_0000, 6);
        @(negedge clk);
        SS_n = 1'b1;
        exp_err.push_back(cyc + 1);
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_rx_data_hold", rx_data, 10'h1C3);

        // Read address then read data with tx handshake.
        rx_frame(1'b1, 10'b10_0000_1111);
        @(negedge clk);
        chk("rd_addr_flag_set", dut.rd_addr_flag_q, 1);
        ss_up();
        rx_frame(1'b1, 10'b11_0000_0000);
        repeat (3) @(negedge clk);
        chk("miso_tx_wait", MISO, 0);
        tx_valid = 1'b1;
        tx_data  = 8'h5A;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'hFF;
        for (int i = TXB - 1; i >= 0; i--) begin
            chk("miso_bit", MISO, tx_exp[i]);
            @(negedge clk);
        end
        chk("miso_after_tx", MISO, 0);
        chk("rd_addr_flag_clr", dut.rd_addr_flag_q, 0);
        ss_up();

        // Timeout: read-data frame with tx_valid never asserted.
        rx_frame(1'b1, 10'b10_1111_0000);
        ss_up();
        rx_frame(1'b1, 10'b11_1010_1010);
        exp_err.push_back(cyc + TWM + 2);
        for (int i = 0; i < TWM + 5; i++) begin
            @(negedge clk);
            chk("miso_timeout", MISO, 0);
        end
        chk("flag_after_timeout", dut.rd_addr_flag_q, 1);
        ss_up();

        // tx_valid outside TX_WAIT is ignored.
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        @(negedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        chk("idle_busy", busy, 0);
        chk("idle_miso", MISO, 0);

        // Reset mid-frame discards the partial frame.
        sel_start(1'b0, ent);
        shift(10'b01_0101_0101, 5);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_rx_data", rx_data, 0);
        chk("midrst_flag", dut.rd_addr_flag_q, 0);
        rst  = 1'b0;
        SS_n = 1'b1;
        rx_frame(1'b0, 10'b00_0011_1100);
        ss_up();

`ifdef SPI_WIDE_PARITY_EN
        // Flipped parity bit: parity_err instead of rx_valid.
        sel_start(1'b0, ent);
        exp_par.push_back(ent + RXB + 1);
        for (int i = 9; i >= 0; i--) begin
            @(negedge clk);
            MOSI = (10'b01_0000_0001 >> i) & 10'd1;
        end
        @(negedge clk);
        MOSI = 1'b1;
        @(negedge clk);
        chk("par_rx_data_hold", rx_data, 10'h03C);
        ss_up();
`endif

        repeat (4) @(negedge clk);
        chk("rx_queue_empty", exp_rx.size(), 0);
        chk("err_queue_empty", exp_err.size(), 0);
        chk("par_queue_empty", exp_par.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_slave_wide.md
Name: spi_slave_wide

Overview:
- Parametrised next-generation SPI slave front end. Frame width, command field and read turnaround are configurable, and it adds explicit frame-error reporting.
- MOSI, SS_n and MISO are sampled and driven on the system clock `clk`; one bit is transferred per `clk` cycle while SS_n is low.
- Sits between the SPI pins and the register/RAM controller: delivers command+payload words on rx_data and serialises read data supplied on tx_data.

Parameters:
- DATA_W, 8: payload width in bits; rx frame width FRAME_W = DATA_W+2.
- TX_WAIT_MAX, 15: max cycles to wait for tx_valid in a read-data frame before aborting (frame_err).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- SS_n  input  1  slave select, active low.
- MOSI  input  1  serial data in, MSB first.
- tx_valid  input  1  tx_data valid, sampled only in read-data wait.
- tx_data  input  DATA_W  read data to return to master.
- MISO  output  1  serial data out, MSB first; 0 when not transmitting.
- rx_valid  output  1  one-cycle pulse: rx_data holds a complete frame.
- rx_data  output  DATA_W+2  [DATA_W+1:DATA_W] = command (00 wr addr, 01 wr data, 10 rd addr, 11 rd data), [DATA_W-1:0] = payload.
- frame_err  output  1  one-cycle pulse on aborted frame.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, MISO=0, rx_valid=0, rx_data=0, frame_err=0, busy=0, rd_addr_flag=0, bit counter=0.
- FSM states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, TX_WAIT, TX_SHIFT.
- IDLE: SS_n=0 sampled -> CHK_CMD.
- CHK_CMD: consumes one selection bit from MOSI.
  - 0 -> WRITE.
  - 1 with rd_addr_flag=0 -> READ_ADD.
  - 1 with rd_addr_flag=1 -> READ_DATA.
- WRITE / READ_ADD / READ_DATA: shift in FRAME_W bits MSB first.
  - rx_data updates in full on the edge sampling bit FRAME_W; rx_valid=1 for that following cycle only.
  - rx_data holds between frames.
- Command bits are passed through unchecked.
- READ_ADD completion sets rd_addr_flag, then returns to IDLE on SS_n=1.
- WRITE completion returns to IDLE on SS_n=1.
- READ_DATA completion -> TX_WAIT.
  - tx_valid=1 captures tx_data -> TX_SHIFT.
  - MISO presents tx_data[DATA_W-1] in the first TX_SHIFT cycle and the next bit each cycle, DATA_W cycles total.
  - Then MISO=0, rd_addr_flag cleared, wait for SS_n=1 -> IDLE.
- Extra MOSI bits after frame completion are ignored; no second rx_valid until SS_n has gone high.
- SS_n=1 mid-frame (CHK_CMD, shift states, TX_WAIT, TX_SHIFT):
  - next state IDLE, frame_err pulse, no rx_valid, rx_data unchanged.
  - rd_addr_flag unchanged, except an aborted TX_SHIFT also leaves it set.
- TX_WAIT exceeding TX_WAIT_MAX cycles: frame_err pulse; MISO stays 0 until SS_n=1 -> IDLE.
- tx_valid is ignored outside TX_WAIT.
- Reset mid-frame: immediate return to reset values; partial frame discarded, no pulses.
- SS_n low continuously across frames: a new frame starts only after SS_n returns high for at least one cycle.

Optional Feature:
- Macro SPI_WIDE_PARITY_EN.
- Defined:
  - each rx frame carries one extra even-parity bit after bit FRAME_W, over the FRAME_W bits.
  - adds output parity_err (1 bit), a one-cycle pulse coincident with where rx_valid would have been.
  - on mismatch rx_valid is suppressed, rx_data is not updated and rd_addr_flag is not changed.
  - TX appends an even-parity bit after the DATA_W data bits.
- Not defined: no parity bit, no parity_err port, frame lengths as above.

Test Plan:
- rst=1 for 2 cycles with SS_n=0 and MOSI toggling -> all outputs 0, busy=0; first frame after release is decoded normally.
- Write address, DATA_W=8: SS_n=0, select 0, bits 00_10100101 -> rx_data=0x0A5, rx_valid high exactly 1 cycle, 11 cycles after CHK_CMD entry; SS_n=1 -> IDLE.
- Write data back-to-back (SS_n high 1 cycle between): bits 01_11000011 -> rx_data=0x1C3, single rx_valid pulse, frame_err never asserts.
- Read pair:
  - rd-addr frame 10_00001111 -> rx_data=0x20F, rd_addr_flag=1.
  - rd-data frame 11_xxxxxxxx -> rx_valid; tx_valid pulse with tx_data=0x5A 3 cycles later -> MISO sequence 0,1,0,1,1,0,1,0; rd_addr_flag=0.
- Abort: SS_n=1 after 4 payload bits of a write -> frame_err 1 cycle, rx_data keeps previous 0x1C3, no rx_valid, busy=0 next cycle.
- Timeout: rd-data frame with tx_valid held 0 for TX_WAIT_MAX+1 cycles -> frame_err pulse; MISO stays 0; with SPI_WIDE_PARITY_EN, a frame with a flipped parity bit -> parity_err pulse and no rx_valid.
